// File: rtl/scratchpad_port_arbiter.sv
// ---------------------------------------------------------------------------
// scratchpad_port_arbiter
//
// Shares one synchronous-read scratchpad SRAM (one cycle read latency) among
// NUM_REQ datapath requesters. At most one transfer (read or write) is granted
// per cycle. Priority is round-robin, and a requester can lock the port to
// run a burst. Read data is broadcast, and a registered per-requester valid
// marks which requester owns the returning word.
//
// Ports:
//   clk                 clock, all state on rising edge
//   reset               asynchronous, active-high reset
//   req_valid[i]        requester i wants one transfer this cycle
//   req_we[i]           1 = write, 0 = read
//   req_lock[i]         keep ownership after this transfer
//   req_addr            packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata           packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_grant           one-hot or zero, combinational grant for this cycle
//   rsp_valid           registered, read data for requester i valid this cycle
//   rsp_data            read data broadcast to all requesters
//   sram_write_enable   SRAM write strobe
//   sram_write_address  SRAM write address
//   sram_write_data     SRAM write data
//   sram_read_address   SRAM read address
//   sram_read_data      SRAM read data, valid one cycle after the address
//   arb_busy            port is locked or a read response is pending
// ---------------------------------------------------------------------------
module scratchpad_port_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ-1:0]             req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             req_grant,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           sram_write_enable,
    output logic [ADDR_WIDTH-1:0]          sram_write_address,
    output logic [DATA_WIDTH-1:0]          sram_write_data,
    output logic [ADDR_WIDTH-1:0]          sram_read_address,
    input  logic [DATA_WIDTH-1:0]          sram_read_data,
    output logic                           arb_busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;

    // Round-robin scan result
    logic               rr_found;
    logic [PTR_W-1:0]   rr_winner;

    // Selected requester (round-robin winner, or lock owner)
    logic [PTR_W-1:0]   sel;
    logic               sel_valid;
    logic               sel_we;
    logic               sel_lock;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic [NUM_REQ-1:0] grant_vec;
    logic               granted;
    logic               grant_write;
    logic               grant_read;

    // Next requester index after p, wrapping at NUM_REQ.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (int'(p) >= NUM_REQ - 1) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // First valid requester scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
    always_comb begin
        logic [PTR_W-1:0] idx;
        rr_found  = 1'b0;
        rr_winner = '0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((32'(rr_ptr) + k) % 32'(NUM_REQ));
            if (!rr_found && req_valid[idx]) begin
                rr_found  = 1'b1;
                rr_winner = idx;
            end
        end
    end

    // While locked only the owner is eligible, even when it is not requesting.
    always_comb begin
        if (state == LOCKED) begin
            sel       = owner;
            sel_valid = req_valid[owner];
        end else begin
            sel       = rr_winner;
            sel_valid = rr_found;
        end
        sel_we    = req_we[sel];
        sel_lock  = req_lock[sel];
        sel_addr  = req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[sel*DATA_WIDTH +: DATA_WIDTH];

        grant_vec = '0;
        if (sel_valid && !reset) begin
            grant_vec[sel] = 1'b1;
        end
    end

    assign granted     = |grant_vec;
    assign grant_write = granted & sel_we;
    assign grant_read  = granted & ~sel_we;

    assign req_grant          = grant_vec;
    assign sram_write_enable  = grant_write;
    assign sram_write_address = grant_write ? sel_addr  : '0;
    assign sram_write_data    = grant_write ? sel_wdata : '0;
    assign sram_read_address  = grant_read  ? sel_addr  : '0;

    assign rsp_data = sram_read_data;
    assign arb_busy = (state == LOCKED) | (|rsp_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            rsp_valid <= '0;
        end else begin
            // Read grant vector delayed by one cycle, aligned with the SRAM data.
            rsp_valid <= grant_read ? grant_vec : '0;

            case (state)
                IDLE: begin
                    if (granted) begin
                        rr_ptr <= ptr_next(sel);
                        if (sel_lock) begin
                            state <= LOCKED;
                            owner <= sel;
                        end
                    end
                end
                LOCKED: begin
                    // rr_ptr stays frozen until the owner's unlocking transfer.
                    if (granted && !sel_lock) begin
                        state  <= IDLE;
                        rr_ptr <= ptr_next(owner);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scratchpad_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_scratchpad_port_arbiter
//
// Directed bench for scratchpad_port_arbiter (NUM_REQ=2). The stimulus
// process drives one request pattern per cycle and pushes the hand-computed
// grant and read-response expectations into queues. The monitor process pops
// and compares whenever the DUT shows a grant or a response. The bench also
// includes a small synchronous-read SRAM model.
// ---------------------------------------------------------------------------
module tb_scratchpad_port_arbiter;

    localparam int NR = 2;
    localparam int AW = 12;
    localparam int DW = 16;

    typedef struct packed {
        logic [NR-1:0] g;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } gexp_t;

    typedef struct packed {
        logic [NR-1:0] v;
        logic [DW-1:0] d;
    } rexp_t;

    logic              clk;
    logic              reset;
    logic [NR-1:0]     rv;
    logic [NR-1:0]     rwe;
    logic [NR-1:0]     rlk;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rwd;
    logic [NR-1:0]     req_grant;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              sram_write_enable;
    logic [AW-1:0]     sram_write_address;
    logic [DW-1:0]     sram_write_data;
    logic [AW-1:0]     sram_read_address;
    logic [DW-1:0]     sram_read_data;
    logic              arb_busy;

    gexp_t gq[$];
    rexp_t rq[$];

    logic  busy_chk;
    logic  exp_busy;
    logic  done;
    int    checks;
    int    failures;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    scratchpad_port_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid          (rv),
        .req_we             (rwe),
        .req_lock           (rlk),
        .req_addr           (raddr),
        .req_wdata          (rwd),
        .req_grant          (req_grant),
        .rsp_valid          (rsp_valid),
        .rsp_data           (rsp_data),
        .sram_write_enable  (sram_write_enable),
        .sram_write_address (sram_write_address),
        .sram_write_data    (sram_write_data),
        .sram_read_address  (sram_read_address),
        .sram_read_data     (sram_read_data),
        .arb_busy           (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: write and registered read on the same edge; preload under reset.
    always @(posedge clk) begin
        if (reset) begin
            mem[12'h010] <= 16'h1111;
            mem[12'h020] <= 16'h2222;
            for (int i = 0; i < 4; i++) begin
                mem[12'h100 + i] <= 16'h5100 + 16'(i);
            end
            sram_read_data <= '0;
        end else begin
            if (sram_write_enable) begin
                mem[sram_write_address] <= sram_write_data;
            end
            sram_read_data <= mem[sram_read_address];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: all comparisons happen here, on the falling edge.
    initial begin
        checks   = 0;
        failures = 0;
        forever begin
            @(negedge clk);
            if (busy_chk) begin
                chk("arb_busy", 64'(arb_busy), 64'(exp_busy));
            end
            if (req_grant != '0) begin
                if (gq.size() == 0) begin
                    chk("unexpected_grant", 64'(req_grant), 64'(0));
                end else begin
                    gexp_t e;
                    e = gq.pop_front();
                    chk("grant", 64'(req_grant), 64'(e.g));
                    chk("sram_we", 64'(sram_write_enable), 64'(e.we));
                    if (e.we) begin
                        chk("sram_waddr", 64'(sram_write_address), 64'(e.addr));
                        chk("sram_wdata", 64'(sram_write_data), 64'(e.wd));
                        chk("sram_raddr_on_write", 64'(sram_read_address), 64'(0));
                    end else begin
                        chk("sram_raddr", 64'(sram_read_address), 64'(e.addr));
                    end
                end
            end else begin
                chk("idle_sram_outputs",
                    {27'd0, sram_write_enable, sram_write_address, sram_write_data, sram_read_address},
                    64'(0));
            end
            if (rsp_valid != '0) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
                end else begin
                    rexp_t r;
                    r = rq.pop_front();
                    chk("rsp_valid", 64'(rsp_valid), 64'(r.v));
                    chk("rsp_data", 64'(rsp_data), 64'(r.d));
                end
            end
            if (done) begin
                chk("grant_queue_drained", 64'(gq.size()), 64'(0));
                chk("rsp_queue_drained", 64'(rq.size()), 64'(0));
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    initial begin
        #3000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        busy_chk = 1'b0;
    endtask

    task automatic push_g(input logic [NR-1:0] g, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        gexp_t e;
        e.g = g; e.we = we; e.addr = a; e.wd = d;
        gq.push_back(e);
    endtask

    task automatic push_r(input logic [NR-1:0] v, input logic [DW-1:0] d);
        rexp_t r;
        r.v = v; r.d = d;
        rq.push_back(r);
    endtask

    task automatic expect_busy(input logic b);
        busy_chk = 1'b1;
        exp_busy = b;
    endtask

    // Stimulus
    initial begin
        done     = 1'b0;
        busy_chk = 1'b0;
        exp_busy = 1'b0;
        reset    = 1'b1;
        rv       = 2'b11;
        rwe      = 2'b00;
        rlk      = 2'b00;
        raddr    = {12'h020, 12'h010};
        rwd      = '0;
        expect_busy(1'b0);

        // 1: reset with both requesting
        cyc(); expect_busy(1'b0);
        cyc(); reset = 1'b0;
        push_g(2'b01, 1'b0, 12'h010, '0); push_r(2'b01, 16'h1111); expect_busy(1'b0);

        // 2: alternating reads
        cyc(); push_g(2'b10, 1'b0, 12'h020, '0); push_r(2'b10, 16'h2222); expect_busy(1'b1);
        cyc(); push_g(2'b01, 1'b0, 12'h010, '0); push_r(2'b01, 16'h1111);
        cyc(); push_g(2'b10, 1'b0, 12'h020, '0); push_r(2'b10, 16'h2222);

        // 3: write then read of the same address
        cyc(); rwe = 2'b01; raddr = {12'h005, 12'h005}; rwd = {16'h0000, 16'hABCD};
        push_g(2'b01, 1'b1, 12'h005, 16'hABCD);
        cyc(); rv = 2'b10; rwe = 2'b00;
        push_g(2'b10, 1'b0, 12'h005, '0); push_r(2'b10, 16'hABCD);

        // move rr_ptr to 1
        cyc(); rv = 2'b01; raddr = {12'h005, 12'h010};
        push_g(2'b01, 1'b0, 12'h010, '0); push_r(2'b01, 16'h1111);

        // 4: locked burst by req1 while req0 keeps requesting
        cyc(); rv = 2'b11; rlk = 2'b10; raddr = {12'h100, 12'h010};
        push_g(2'b10, 1'b0, 12'h100, '0); push_r(2'b10, 16'h5100); expect_busy(1'b1);
        cyc(); raddr = {12'h101, 12'h010};
        push_g(2'b10, 1'b0, 12'h101, '0); push_r(2'b10, 16'h5101); expect_busy(1'b1);
        cyc(); raddr = {12'h102, 12'h010};
        push_g(2'b10, 1'b0, 12'h102, '0); push_r(2'b10, 16'h5102); expect_busy(1'b1);
        cyc(); rlk = 2'b00; raddr = {12'h103, 12'h010};
        push_g(2'b10, 1'b0, 12'h103, '0); push_r(2'b10, 16'h5103); expect_busy(1'b1);
        cyc(); rv = 2'b01;
        push_g(2'b01, 1'b0, 12'h010, '0); push_r(2'b01, 16'h1111); expect_busy(1'b1);

        // 5: owner idles while locked
        cyc(); rv = 2'b11; rlk = 2'b10; raddr = {12'h020, 12'h010};
        push_g(2'b10, 1'b0, 12'h020, '0); push_r(2'b10, 16'h2222);
        cyc(); rv = 2'b01; rlk = 2'b00; expect_busy(1'b1);
        cyc(); rlk = 2'b10; expect_busy(1'b1);
        cyc(); rlk = 2'b00; expect_busy(1'b1);
        cyc(); rv = 2'b11;
        push_g(2'b10, 1'b0, 12'h020, '0); push_r(2'b10, 16'h2222); expect_busy(1'b1);

        // 6: reset during the cycle after a locking read grant to req0
        cyc(); rv = 2'b01; rlk = 2'b01;
        push_g(2'b01, 1'b0, 12'h010, '0);
        cyc(); reset = 1'b1; rv = 2'b11; rlk = 2'b00; expect_busy(1'b0);
        cyc(); reset = 1'b0;
        push_g(2'b01, 1'b0, 12'h010, '0); push_r(2'b01, 16'h1111); expect_busy(1'b0);
        cyc(); rv = 2'b10;
        push_g(2'b10, 1'b0, 12'h020, '0); push_r(2'b10, 16'h2222);
        cyc(); rv = 2'b00;
        cyc(); expect_busy(1'b0); done = 1'b1;
    end

endmodule

// File: doc/scratchpad_port_arbiter.md
Name: scratchpad_port_arbiter

Overview:
Shares the single scratchpad SRAM (12-bit address, 16-bit data, synchronous read with one cycle of latency) among NUM_REQ datapath requesters, for example the convolution engine and the pooling/writeback engine inside MyDesign.
- Grants at most one transfer (read or write) per cycle using round-robin priority.
- Supports a lock so one requester can own the port for a burst.
- Routes read data back to the requester that issued the read.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ADDR_WIDTH, 12, SRAM address width
DATA_WIDTH, 16, SRAM data width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  requester i wants one transfer this cycle
req_we  in  NUM_REQ  1=write, 0=read, per requester
req_lock  in  NUM_REQ  requester wants to keep ownership after this transfer
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
req_grant  out  NUM_REQ  one-hot or zero; transfer accepted this cycle
rsp_valid  out  NUM_REQ  registered; read data for requester i is valid this cycle
rsp_data  out  DATA_WIDTH  read data, broadcast to all requesters (= sram_read_data)
sram_write_enable  out  1  to SRAM write_enable
sram_write_address  out  ADDR_WIDTH  to SRAM write_address
sram_write_data  out  DATA_WIDTH  to SRAM write_data
sram_read_address  out  ADDR_WIDTH  to SRAM read_address
sram_read_data  in  DATA_WIDTH  from SRAM read_data, valid one cycle after address
arb_busy  out  1  state is LOCKED or a read response is pending

Behaviour:
- While reset is high:
  - state=IDLE, rr_ptr=0, owner=0, rsp_valid=0.
  - req_grant=0 and sram_write_enable=0 (combinationally gated by reset).
  - sram_*_address=0, sram_write_data=0, arb_busy=0.
- Grant is combinational in the same cycle as req_valid.
  - A requester holds req_valid, req_we, req_addr, req_wdata and req_lock stable until it sees req_grant.
  - A transfer completes in the cycle where req_valid & req_grant are both high.
- IDLE arbitration:
  - Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - On a grant, rr_ptr <= (winner+1) mod NUM_REQ. With no requests, rr_ptr is unchanged.
- LOCKED(owner):
  - Only the owner can be granted; other requesters wait (grant=0) even if the owner is idle.
  - rr_ptr is frozen while LOCKED.
- State transitions:
  - IDLE -> LOCKED(owner=winner) when the granted transfer has req_lock=1.
  - LOCKED -> IDLE in the cycle the owner has a granted transfer with req_lock=0; rr_ptr <= owner+1 on that edge.
  - LOCKED with owner req_valid=0: stay LOCKED, whatever the owner's req_lock is.
- Granted write:
  - sram_write_enable=1; sram_write_address and sram_write_data come from the winner's fields.
  - sram_read_address=0 that cycle.
- Granted read:
  - sram_read_address = winner address, sram_write_enable=0.
  - Next cycle: rsp_valid[winner]=1 and rsp_data carries the SRAM data.
- Back-to-back reads are fully pipelined, one per cycle. rsp_valid is one-hot at most and is exactly the read grant vector delayed by one cycle.
- No grant in a cycle: sram_write_enable=0, addresses=0, rsp_valid=0 the following cycle.
- Read/write ordering:
  - A write to address A followed by a read of A in the next cycle returns the new data (the SRAM writes on the edge).
  - The arbiter adds no reordering.
- arb_busy = (state==LOCKED) | (|rsp_valid).
- Reset mid-burst:
  - Any in-flight response is dropped (rsp_valid forced 0) and the lock is released.
  - Requesters must reissue their transfers.
- With NUM_REQ=1 the block degenerates to a pass-through with registered rsp_valid.

Test Plan:
1. reset=1 while req_valid=2'b11 -> req_grant=0, sram_write_enable=0, rsp_valid=0. Release reset; the first grant goes to req 0 (rr_ptr=0).
2. Both requesters reading continuously, addresses 0x010 (req0) and 0x020 (req1), SRAM preloaded with mem[0x010]=0x1111 and mem[0x020]=0x2222 -> grants alternate 01,10,01,10. rsp_valid follows one cycle later each time, with rsp_data=0x1111 and 0x2222 respectively.
3. req0 writes 0xABCD to 0x005 and req1 reads 0x005 in the same cycle, rr_ptr=0 -> req0 granted first (write), req1 granted next cycle and gets rsp_data=0xABCD one cycle after its grant.
4. req1 issues 4 reads at 0x100..0x103 with req_lock=1,1,1,0 while req0 is requesting continuously -> req1 is granted 4 consecutive times and arb_busy=1 throughout. req0 is granted in the cycle after the unlock transfer.
5. In LOCKED(owner=1), owner drops req_valid for 3 cycles while req0 requests -> req0 gets no grant and state stays LOCKED.
6. Assert reset during the cycle after a read grant to req0 -> rsp_valid[0] stays 0 and state returns to IDLE with rr_ptr=0.
